// File: rtl/slt_serial.sv
// -----------------------------------------------------------------------------
// slt_serial
//
// Bit-serial set-less-than comparator. One bit pair is examined per clock,
// from MSB down to LSB, and the first differing bit decides the result.
// Both signed (slt) and unsigned (sltu) compares are supported.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        asynchronous active-high reset
//   start        request a compare (honoured only while idle)
//   a, b         32-bit operands, captured when start is accepted
//   is_unsigned  1 = unsigned compare, 0 = signed compare
//   busy         high while a compare is in progress (RUN and DONE)
//   done         one-cycle pulse when lt/eq are valid
//   lt           result flag, 1 when A < B
//   eq           equality flag, 1 when A == B
//
// Build option
//   SLT_SERIAL_EARLY_EXIT_EN  when defined, RUN ends on the first differing
//                             bit instead of always scanning all 32 bits.
//                             Results are identical; only latency changes.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; lt/eq hold the previous result
// RUN   | scanning one latched bit pair per cycle, MSB to LSB
// DONE  | result valid, done pulses for this single cycle
// -----------------------------------------------------------------------------
module slt_serial (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_unsigned,
    output logic        busy,
    output logic        done,
    output logic        lt,
    output logic        eq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        uns_q;
    logic [4:0]  idx;
    logic        decided;

    logic        accept;
    logic        bit_a;
    logic        bit_b;
    logic        bit_diff;
    logic        first_diff;
    logic        bit_lt;
    logic        last_bit;

    // Bit-pair evaluation at the current index.
    always_comb begin
        bit_a      = a_q[idx];
        bit_b      = b_q[idx];
        bit_diff   = bit_a ^ bit_b;
        first_diff = bit_diff & ~decided;
        last_bit   = (idx == 5'd0);
        // The sign bit is the only place where the two modes disagree: in a
        // signed compare a set MSB marks the negative, i.e. lesser, operand.
        // Everywhere else A < B exactly when b holds the 1.
        if ((idx == 5'd31) && !uns_q) begin
            bit_lt = bit_a;
        end else begin
            bit_lt = bit_b;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
`ifdef SLT_SERIAL_EARLY_EXIT_EN
                if (first_diff) begin
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, bit index and result flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            uns_q   <= 1'b0;
            idx     <= 5'd31;
            decided <= 1'b0;
            lt      <= 1'b0;
            eq      <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            uns_q   <= is_unsigned;
            idx     <= 5'd31;
            decided <= 1'b0;
            // Preload the "all bits equal" answer; the first differing bit
            // overwrites it, otherwise it is already correct at the end.
            lt      <= 1'b0;
            eq      <= 1'b1;
        end else if (state == RUN) begin
            if (first_diff) begin
                lt      <= bit_lt;
                eq      <= 1'b0;
                decided <= 1'b1;
            end
            // Hold at 0 rather than wrapping back to 31.
            if (!last_bit) begin
                idx <= idx - 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_slt_serial.sv
// -----------------------------------------------------------------------------
// tb_slt_serial
//
// Directed self-checking bench for slt_serial. Each vector carries its
// hand-computed lt/eq and the index of the first differing bit (-1 when the
// operands are equal), from which the expected latency for the current build
// is derived.
// -----------------------------------------------------------------------------
module tb_slt_serial;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_unsigned;
    logic        busy;
    logic        done;
    logic        lt;
    logic        eq;

    int n_vec;
    int n_err;

    slt_serial dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
        .is_unsigned (is_unsigned),
        .busy        (busy),
        .done        (done),
        .lt          (lt),
        .eq          (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_cmp(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic vu, input logic elt, input logic eeq, input int k);
        int cyc;
        int exp_lat;
        exp_lat = 33;
`ifdef SLT_SERIAL_EARLY_EXIT_EN
        if (k >= 0) exp_lat = 33 - k;
`endif
        a = va;
        b = vb;
        is_unsigned = vu;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scrambling the ports after acceptance must not affect the result.
        a = ~va;
        b = ~vb;
        is_unsigned = ~vu;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        cyc = 1;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_lt"}, {31'd0, lt}, {31'd0, elt});
        check({tag, "_eq"}, {31'd0, eq}, {31'd0, eeq});
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
        check({tag, "_hold"}, {30'd0, lt, eq}, {30'd0, elt, eeq});
    endtask

    initial begin
        int nd;
        logic hold_lt;
        logic hold_eq;
        n_vec = 0;
        n_err = 0;
        hold_lt = 1'b0;
        hold_eq = 1'b0;

        // Reset held together with start: reset must win.
        reset = 1'b1;
        start = 1'b1;
        a = 32'h1;
        b = 32'h2;
        is_unsigned = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {28'd0, busy, done, lt, eq}, 32'd0);
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_idle", {31'd0, busy}, 32'd0);

        run_cmp("slt_neg",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 31);
        run_cmp("sltu_big",  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 31);
        run_cmp("equal",     32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1, -1);
        run_cmp("lsb_lt",    32'h0000_0004, 32'h0000_0005, 1'b0, 1'b1, 1'b0, 0);
        run_cmp("lsb_gt_u",  32'h0000_0005, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 0);
        run_cmp("slt_min",   32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 31);
        run_cmp("sltu_min",  32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 31);
        run_cmp("mid_bit17", 32'h0001_0000, 32'h0002_0000, 1'b0, 1'b1, 1'b0, 17);
        run_cmp("neg_pair",  32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 0);
        run_cmp("sltu_eqz",  32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, -1);

        // Reset abort, ~10 cycles into RUN.
        a = 32'hA5A5_A5A5;
        b = 32'hA5A5_A5A5;
        is_unsigned = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_now", {28'd0, busy, done, lt, eq}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        check("abort_nodone", 32'(nd), 32'd0);
        run_cmp("after_abort", 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 31);

        // Start with different operands mid-RUN must be ignored.
        a = 32'h0000_0003;
        b = 32'h0000_0003;
        is_unsigned = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        a = 32'h0000_0000;
        b = 32'hFFFF_FFFF;
        is_unsigned = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nd = 0;
        repeat (45) begin
            @(posedge clk);
            #1;
            if (done) begin
                nd++;
                hold_lt = lt;
                hold_eq = eq;
            end
        end
        check("busy_rej_pulses", 32'(nd), 32'd1);
        check("busy_rej_result", {30'd0, hold_lt, hold_eq}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
